// File: rtl/dnn_pkg.sv
// Types and constants shared by the DNN output-layer blocks.
package dnn_pkg;

    typedef enum logic [1:0] {MF_IDLE, MF_ACCUM, MF_DONE} mf_state_t;

    localparam logic MF_MODE_MAX = 1'b0;
    localparam logic MF_MODE_MIN = 1'b1;

endpackage

// File: rtl/argmax_lane.sv
// Combinational extreme-value finder across the M lanes of one beat.
// Only lanes set in the mask are eligible; the lowest lane index wins ties.
module argmax_lane
    import dnn_pkg::*;
#(
    parameter int width = 13,
    parameter int M     = 4,
    parameter int LW    = (M > 1) ? $clog2(M) : 1
) (
    input  logic [M-1:0][width-1:0] i_lanes,
    input  logic [M-1:0]            i_mask,
    input  logic                    i_mode,
    output logic [width-1:0]        o_val,
    output logic [LW-1:0]           o_idx
);

    logic w_found;

    // Strict comparison while scanning upward keeps the earliest lane on ties.
    always_comb begin
        w_found = 1'b0;
        o_val   = '0;
        o_idx   = '0;
        for (int l = 0; l < M; l++) begin
            if (i_mask[l] && (!w_found ||
                ((i_mode == MF_MODE_MIN) ? ($signed(i_lanes[l]) < $signed(o_val))
                                         : ($signed(i_lanes[l]) > $signed(o_val))))) begin
                o_val   = i_lanes[l];
                o_idx   = LW'(l);
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/max_finder_stream.sv
// Streaming argmax/argmin over N signed values delivered M per beat.
// Keeps a running best across beats and presents it on a valid/ready output.
module max_finder_stream
    import dnn_pkg::*;
#(
    parameter int width    = 13,
    parameter int N        = 37,
    parameter int M        = 4,
    parameter int poswidth = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [M-1:0][width-1:0] in,
    input  logic                    mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [width-1:0]        out,
    output logic [poswidth-1:0]     pos
);

    localparam int BEATS = (N + M - 1) / M;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW    = (M > 1) ? $clog2(M) : 1;

    mf_state_t                r_state;
    logic [BW-1:0]            r_beat;
    logic signed [width-1:0]  r_best;
    logic [poswidth-1:0]      r_best_pos;
    logic                     r_mode;
    logic                     r_out_valid;
    logic [width-1:0]         r_out;
    logic [poswidth-1:0]      r_pos;

    logic [M-1:0]             w_mask;
    logic                     w_mode;
    logic signed [width-1:0]  w_lane_val;
    logic [LW-1:0]            w_lane_idx;
    logic [poswidth-1:0]      w_lane_pos;
    logic                     w_accept;
    logic                     w_last;
    logic                     w_take;
    logic signed [width-1:0]  w_next_val;
    logic [poswidth-1:0]      w_next_pos;

    // Lanes past element N-1 only occur on the final beat and are never eligible.
    for (genvar gi = 0; gi < M; gi++) begin : g_mask
        assign w_mask[gi] = ((32'(r_beat) * 32'(M) + 32'(gi)) < 32'(N));
    end

    assign w_mode = (r_state == MF_IDLE) ? mode : r_mode;

    argmax_lane #(
        .width (width),
        .M     (M),
        .LW    (LW)
    ) u_lane (
        .i_lanes (in),
        .i_mask  (w_mask),
        .i_mode  (w_mode),
        .o_val   (w_lane_val),
        .o_idx   (w_lane_idx)
    );

    assign in_ready   = !reset && (r_state != MF_DONE);
    assign w_accept   = in_valid && in_ready;
    assign w_lane_pos = poswidth'(32'(r_beat) * 32'(M) + 32'(w_lane_idx));

    // The beat counter is zero in IDLE, so a single-beat vector finishes immediately.
    assign w_last = (r_beat == BW'(BEATS - 1));
    assign w_take = (r_state == MF_IDLE) ||
                    ((r_mode == MF_MODE_MIN) ? (w_lane_val < r_best) : (w_lane_val > r_best));
    assign w_next_val = w_take ? w_lane_val : r_best;
    assign w_next_pos = w_take ? w_lane_pos : r_best_pos;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= MF_IDLE;
            r_beat      <= '0;
            r_best      <= '0;
            r_best_pos  <= '0;
            r_mode      <= MF_MODE_MAX;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_pos       <= '0;
        end else begin
            case (r_state)
                MF_IDLE, MF_ACCUM: begin
                    if (w_accept) begin
                        r_best     <= w_next_val;
                        r_best_pos <= w_next_pos;
                        if (r_state == MF_IDLE) begin
                            r_mode <= mode;
                        end
                        if (w_last) begin
                            r_beat      <= '0;
                            r_out       <= w_next_val;
                            r_pos       <= w_next_pos;
                            r_out_valid <= 1'b1;
                            r_state     <= MF_DONE;
                        end else begin
                            r_beat  <= r_beat + 1'b1;
                            r_state <= MF_ACCUM;
                        end
                    end
                end
                MF_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= MF_IDLE;
                    end
                end
                default: r_state <= MF_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign pos       = r_pos;

endmodule
